// File: rtl/spike_evt_pkg.sv
// spike_evt_pkg: shared FSM encoding, frame and event width constants for the spike event serializer
package spike_evt_pkg;
    typedef enum logic [2:0] {IDLE, SYNC, TS_HI, TS_LO, AMP_HI, AMP_LO} state_t;
    localparam int FRAME_BYTES = 5;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int TS_W = 16;
    localparam int AMP_W = 16;
    localparam int EVT_W = TS_W + AMP_W;
endpackage

// File: rtl/spike_evt_fifo.sv
// spike_evt_fifo: synchronous event FIFO, EVT_W x DEPTH
// ports: clk, rst_n (sync active-low), push/din write, pop/dout read (dout shows head),
//        full, empty, level (registered occupancy)
module spike_evt_fifo
    import spike_evt_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [EVT_W-1:0] din,
    output logic [EVT_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
endmodule

// File: rtl/spike_event_serializer.sv
// spike_event_serializer: timestamps spike pulses, buffers them and emits 5-byte frames
// ports: clk, rst_n (sync active-low); spike_in/amp_in event capture;
//        out_data/out_valid/out_ready byte stream; overflow_clr, overflow, drop_cnt drop
//        accounting; fifo_level buffer occupancy
module spike_event_serializer
    import spike_evt_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spike_in,
    input  logic [AMP_W-1:0]  amp_in,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              overflow_clr,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    output logic [LW-1:0]     fifo_level
);
    logic [TS_W-1:0] ts;
    logic [EVT_W-1:0] frame, head;
    state_t state;
    logic full, empty, hs, pop, push, drop;

    assign hs   = out_valid && out_ready;
    // the head is pulled either from idle or straight out of an accepted last byte
    assign pop  = !empty && (state == IDLE || (state == AMP_LO && hs));
    // a full FIFO still takes the event when the head leaves in the same cycle
    assign push = spike_in && (!full || pop);
    assign drop = spike_in && !push;

    spike_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({ts, amp_in}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts        <= '0;
            frame     <= '0;
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            ts       <= ts + 16'd1;
            overflow <= !overflow_clr && (overflow || drop);
            drop_cnt <= overflow_clr ? 8'd0 : (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
            if (pop) begin
                frame     <= head;
                state     <= SYNC;
                out_valid <= 1'b1;
                out_data  <= SYNC_BYTE;
            end else if (hs) begin
                // frame shifts left so its top byte is always the next one to send
                out_data  <= state == AMP_LO ? 8'h00 : frame[EVT_W-1 -: 8];
                frame     <= frame << 8;
                out_valid <= state != AMP_LO;
                state     <= state == AMP_LO ? IDLE : state_t'(state + 3'd1);
            end
        end
    end
endmodule

// File: tb/tb_spike_event_serializer.sv
// tb_spike_event_serializer: scoreboard bench for spike_event_serializer
module tb_spike_event_serializer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spike_in = 1'b0;
    logic [15:0] amp_in = '0;
    logic out_ready = 1'b0;
    logic overflow_clr = 1'b0;
    logic [7:0] out_data;
    logic out_valid;
    logic overflow;
    logic [7:0] drop_cnt;
    logic [$clog2(DEPTH):0] fifo_level;

    spike_event_serializer #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spike_in     (spike_in),
        .amp_in       (amp_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow_clr (overflow_clr),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];
    logic [15:0] tb_ts = '0;
    int cyc = 0;
    int vcnt = 0;
    int vfirst = -1;
    int vlast = -1;
    int lvl_max = 0;

    always @(posedge clk) begin
        tb_ts <= !rst_n ? 16'h0 : tb_ts + 16'h1;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h expected no byte", out_data);
            end else begin
                check("frame_byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
        if (out_valid) begin
            vcnt++;
            if (vfirst < 0) vfirst = cyc;
            vlast = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic spike(input logic [15:0] amp, input bit acc);
        spike_in = 1'b1;
        amp_in = amp;
        if (acc) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(tb_ts[15:8]);
            exp_q.push_back(tb_ts[7:0]);
            exp_q.push_back(amp[15:8]);
            exp_q.push_back(amp[7:0]);
        end
        tick();
        spike_in = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        check("wait_valid", {31'h0, out_valid}, 32'h1);
    endtask

    task automatic wait_ts(input logic [15:0] v);
        for (int i = 0; i < 70000 && tb_ts != v; i++) tick();
        check("wait_ts", {16'h0, tb_ts}, {16'h0, v});
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
        check("drain_left", exp_q.size(), 0);
        @(negedge clk);
        check("drain_idle", {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        do_reset(2);
        @(negedge clk);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data", {24'h0, out_data}, 32'h0);
        check("rst_level", {29'h0, fifo_level}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_drop", {24'h0, drop_cnt}, 32'h0);

        out_ready = 1'b1;
        wait_ts(16'h0012);
        spike(16'h01F4, 1'b1);
        @(negedge clk);
        check("lat_t1_valid", {31'h0, out_valid}, 32'h0);
        tick();
        @(negedge clk);
        check("lat_t2_sync", {23'h0, out_valid, out_data}, {23'h0, 1'b1, 8'hA5});
        drain(20);

        out_ready = 1'b0;
        spike(16'hBEEF, 1'b1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {23'h0, out_valid, out_data}, {23'h0, 1'b1, 8'hA5});
            tick();
        end
        out_ready = 1'b1;
        drain(20);

        vcnt = 0;
        vfirst = -1;
        vlast = -1;
        lvl_max = 0;
        spike(16'h0101, 1'b1);
        spike(16'h0202, 1'b1);
        spike(16'h0303, 1'b1);
        drain(40);
        check("b2b_valid_cnt", vcnt, 15);
        check("b2b_contig", vlast - vfirst, 14);
        check("b2b_lvl_peak", lvl_max, 2);

        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) spike(16'h1000 + 16'(i), i < 5);
        @(negedge clk);
        check("ovf_level", {29'h0, fifo_level}, 32'd4);
        check("ovf_drop", {24'h0, drop_cnt}, 32'd2);
        check("ovf_flag", {31'h0, overflow}, 32'h1);
        overflow_clr = 1'b1;
        spike(16'h9999, 1'b0);
        overflow_clr = 1'b0;
        @(negedge clk);
        check("clr_wins_drop", {24'h0, drop_cnt}, 32'd0);
        check("clr_wins_flag", {31'h0, overflow}, 32'h0);
        for (int i = 0; i < 260; i++) spike(16'h5555, 1'b0);
        @(negedge clk);
        check("drop_sat", {24'h0, drop_cnt}, 32'd255);
        check("sat_flag", {31'h0, overflow}, 32'h1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        @(negedge clk);
        check("clr_drop", {24'h0, drop_cnt}, 32'd0);
        check("clr_flag", {31'h0, overflow}, 32'h0);
        out_ready = 1'b1;
        drain(60);
        check("ovf_drained_level", {29'h0, fifo_level}, 32'd0);

        wait_ts(16'hFFFF);
        spike(16'h0A0A, 1'b1);
        spike(16'h0B0B, 1'b1);
        drain(30);

        out_ready = 1'b0;
        spike(16'h2222, 1'b1);
        spike(16'h3333, 1'b1);
        spike(16'h4444, 1'b1);
        wait_valid();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("mid_level", {29'h0, fifo_level}, 32'd2);
        do_reset(1);
        @(negedge clk);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_level", {29'h0, fifo_level}, 32'd0);
        out_ready = 1'b1;
        repeat (20) tick();
        check("post_rst_ts", {16'h0, tb_ts}, 32'h14);
        spike(16'h7777, 1'b1);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
